vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 145 ++++++++++++++
 tb/tb_vram_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Arbitrates a shared video RAM between a CPU and a VPU DMA engine using a halt/hold handshake.
// Optional grant timeout with sticky error flag is enabled by defining VRAM_ARB_TIMEOUT_EN.
module vram_arbiter #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        vramcs,
    input  logic [15:0] VADDR,
    output logic [7:0]  VDATA,
    output logic        hlda,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_do,
    output logic [7:0]  cpu_di,
    input  logic        cpu_rw,
    input  logic        cpu_vma,
    input  logic        cpu_ba,
    output logic        cpu_halt,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_di,
    input  logic [7:0]  mem_do,
    output logic        mem_cs,
    output logic        mem_we,
    output logic        arb_err
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HALT_REQ = 2'd1,
        S_GRANTED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        cpu_halt_q, cpu_halt_d;
    logic        hlda_q, hlda_d;
    logic [7:0]  vdata_q, vdata_d;
    logic        tmo_c;
    logic        block_c;

`ifdef VRAM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             blk_q, blk_d;

    // cnt_d is the number of granted cycles including the current one
    always_comb begin
        cnt_d = '0;
        if (state_q == S_GRANTED) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        tmo_c = (state_q == S_GRANTED) && (cnt_d == CNT_W'(TIMEOUT));
        err_d = err_q | tmo_c;
        blk_d = tmo_c | (blk_q & hold);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
            blk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            blk_q <= blk_d;
        end
    end

    assign block_c = blk_q;
    assign arb_err = err_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^32'(TIMEOUT);
    assign tmo_c          = 1'b0;
    assign block_c        = 1'b0;
    assign arb_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cpu_halt_q <= 1'b0;
            hlda_q     <= 1'b0;
            vdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            cpu_halt_q <= cpu_halt_d;
            hlda_q     <= hlda_d;
            vdata_q    <= vdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (hold && !block_c) state_d = S_HALT_REQ;
            S_HALT_REQ: begin
                if (!hold) begin
                    state_d = S_IDLE;
                end else if (cpu_ba) begin
                    state_d = S_GRANTED;
                end
            end
            S_GRANTED:  if (!hold || tmo_c) state_d = S_RELEASE;
            S_RELEASE:  state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Halt stays up through the turnaround cycle; grant tracks GRANTED exactly
    always_comb begin
        cpu_halt_d = (state_d != S_IDLE);
        hlda_d     = (state_d == S_GRANTED);
        vdata_d    = vdata_q;
        if (state_q == S_GRANTED && vramcs) begin
            vdata_d = mem_do;
        end
        mem_addr = cpu_addr;
        mem_di   = cpu_do;
        mem_cs   = cpu_vma;
        mem_we   = cpu_vma & ~cpu_rw;
        case (state_q)
            S_GRANTED: begin
                mem_addr = VADDR;
                mem_cs   = vramcs;
                mem_we   = 1'b0;
            end
            S_RELEASE: begin
                mem_cs = 1'b0;
                mem_we = 1'b0;
            end
            default: ;
        endcase
    end

    assign cpu_halt = cpu_halt_q;
    assign hlda     = hlda_q;
    assign VDATA    = vdata_q;
    assign cpu_di   = mem_do;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: CPU passthrough, halt/grant handshake, VPU reads, reset and timeout.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        vramcs;
    logic [15:0] VADDR;
    logic [7:0]  VDATA;
    logic        hlda;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_do;
    logic [7:0]  cpu_di;
    logic        cpu_rw;
    logic        cpu_vma;
    logic        cpu_ba;
    logic        cpu_halt;
    logic [15:0] mem_addr;
    logic [7:0]  mem_di;
    logic [7:0]  mem_do;
    logic        mem_cs;
    logic        mem_we;
    logic        arb_err;

    int total = 0;
    int bad   = 0;

    vram_arbiter #(.TIMEOUT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .vramcs   (vramcs),
        .VADDR    (VADDR),
        .VDATA    (VDATA),
        .hlda     (hlda),
        .cpu_addr (cpu_addr),
        .cpu_do   (cpu_do),
        .cpu_di   (cpu_di),
        .cpu_rw   (cpu_rw),
        .cpu_vma  (cpu_vma),
        .cpu_ba   (cpu_ba),
        .cpu_halt (cpu_halt),
        .mem_addr (mem_addr),
        .mem_di   (mem_di),
        .mem_do   (mem_do),
        .mem_cs   (mem_cs),
        .mem_we   (mem_we),
        .arb_err  (arb_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; hold = 1'b0; vramcs = 1'b0; VADDR = 16'h0000;
        cpu_addr = 16'h0000; cpu_do = 8'h00; cpu_rw = 1'b1; cpu_vma = 1'b0;
        cpu_ba = 1'b0; mem_do = 8'h00;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_hlda", 32'(hlda), 32'h0);
        chk("rst_halt", 32'(cpu_halt), 32'h0);
        chk("rst_vdata", 32'(VDATA), 32'h00);
        chk("rst_err", 32'(arb_err), 32'h0);

        // CPU write passes straight through while idle
        cpu_addr = 16'h1234; cpu_do = 8'hA5; cpu_rw = 1'b0; cpu_vma = 1'b1; mem_do = 8'h5A;
        #1;
        chk("idle_addr", 32'(mem_addr), 32'h1234);
        chk("idle_we", 32'(mem_we), 32'h1);
        chk("idle_di", 32'(mem_di), 32'hA5);
        chk("idle_cs", 32'(mem_cs), 32'h1);
        chk("cpu_di", 32'(cpu_di), 32'h5A);
        cpu_rw = 1'b1;
        #1;
        chk("idle_rd_we", 32'(mem_we), 32'h0);
        cpu_rw = 1'b0;

        // Halt request, bus grant three cycles later
        hold = 1'b1; VADDR = 16'h4000;
        tick();
        chk("hreq_halt", 32'(cpu_halt), 32'h1);
        chk("hreq_hlda", 32'(hlda), 32'h0);
        chk("hreq_addr", 32'(mem_addr), 32'h1234);
        tick(); tick();
        chk("hreq_wait_hlda", 32'(hlda), 32'h0);
        cpu_ba = 1'b1;
        tick();
        chk("grant_hlda", 32'(hlda), 32'h1);
        chk("grant_addr", 32'(mem_addr), 32'h4000);
        chk("grant_we", 32'(mem_we), 32'h0);
        chk("grant_cs_off", 32'(mem_cs), 32'h0);
        vramcs = 1'b1; mem_do = 8'h3C;
        #1;
        chk("grant_cs_on", 32'(mem_cs), 32'h1);
        tick();
        chk("vdata_load", 32'(VDATA), 32'h3C);
        chk("grant_we2", 32'(mem_we), 32'h0);
        vramcs = 1'b0; mem_do = 8'h77;
        tick();
        chk("vdata_hold", 32'(VDATA), 32'h3C);
        chk("grant_stays", 32'(hlda), 32'h1);

        // Release with one turnaround cycle; hold during RELEASE ignored
        hold = 1'b0; cpu_ba = 1'b0;
        tick();
        chk("rel_hlda", 32'(hlda), 32'h0);
        chk("rel_halt", 32'(cpu_halt), 32'h1);
        chk("rel_cs", 32'(mem_cs), 32'h0);
        chk("rel_we", 32'(mem_we), 32'h0);
        hold = 1'b1;
        tick();
        chk("back_idle_halt", 32'(cpu_halt), 32'h0);
        chk("back_idle_we", 32'(mem_we), 32'h1);
        tick();
        chk("rearb_halt", 32'(cpu_halt), 32'h1);

        // Abort before cpu_ba
        hold = 1'b0;
        tick();
        chk("abort_halt", 32'(cpu_halt), 32'h0);
        chk("abort_hlda", 32'(hlda), 32'h0);
        tick();
        chk("abort_stay_halt", 32'(cpu_halt), 32'h0);
        chk("abort_addr", 32'(mem_addr), 32'h1234);

        // Reset in the middle of a grant
        hold = 1'b1; cpu_ba = 1'b1;
        tick(); tick();
        chk("g2_hlda", 32'(hlda), 32'h1);
        vramcs = 1'b1; mem_do = 8'h99;
        tick();
        chk("g2_vdata", 32'(VDATA), 32'h99);
        rst = 1'b1;
        tick();
        rst = 1'b0; hold = 1'b0; cpu_ba = 1'b0; vramcs = 1'b0;
        #1;
        chk("midrst_hlda", 32'(hlda), 32'h0);
        chk("midrst_halt", 32'(cpu_halt), 32'h0);
        chk("midrst_vdata", 32'(VDATA), 32'h00);
        chk("midrst_addr", 32'(mem_addr), 32'h1234);
        chk("midrst_we", 32'(mem_we), 32'h1);

`ifdef VRAM_ARB_TIMEOUT_EN
        hold = 1'b1; cpu_ba = 1'b1;
        tick(); tick();
        n = 0;
        while (hlda === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("tmo_cycles", 32'(n), 32'd15);
        chk("tmo_err", 32'(arb_err), 32'h1);
        chk("tmo_rel_halt", 32'(cpu_halt), 32'h1);
        tick(); tick(); tick(); tick();
        chk("tmo_no_regrant_halt", 32'(cpu_halt), 32'h0);
        chk("tmo_no_regrant_hlda", 32'(hlda), 32'h0);
        hold = 1'b0;
        tick();
        hold = 1'b1;
        tick();
        chk("tmo_rearb_halt", 32'(cpu_halt), 32'h1);
        tick();
        chk("tmo_regrant", 32'(hlda), 32'h1);
        chk("tmo_err_sticky", 32'(arb_err), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0; hold = 1'b0; cpu_ba = 1'b0;
        #1;
        chk("tmo_err_clr", 32'(arb_err), 32'h0);
`else
        hold = 1'b1; cpu_ba = 1'b1;
        tick(); tick();
        for (int i = 0; i < 40; i++) tick();
        chk("long_grant", 32'(hlda), 32'h1);
        chk("long_err", 32'(arb_err), 32'h0);
        hold = 1'b0;
        tick();
        chk("long_rel", 32'(hlda), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
